mult_div_unit: RTL

- Multicycle signed multiply/divide unit owning the HI/LO registers for the multicycle MIPS datapath.
- Sits directly downstream of the control FSM. Control raises a start strobe from its Mult/Div states, stalls until done, then reads hi/lo in its Mfhi/Mflo states.
- The div_zero flag feeds the control FSM's Div_Zero exception path.

---
 rtl/mult_div_if.sv | 17 +
 rtl/mult_div_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/mult_div_if.sv
// mult_div_if: start/operand/result bus between the control FSM (master) and mult_div_unit (slave)
interface mult_div_if #(parameter int WIDTH = 32);
  logic mult_start, div_start;
  logic [WIDTH-1:0] a, b;
`ifdef MULTDIV_UNSIGNED_EN
  logic unsigned_op;
`endif
  logic busy, done, div_zero;
  logic [WIDTH-1:0] hi, lo;
`ifdef MULTDIV_UNSIGNED_EN
  modport master(output mult_start, div_start, a, b, unsigned_op, input busy, done, div_zero, hi, lo);
  modport slave(input mult_start, div_start, a, b, unsigned_op, output busy, done, div_zero, hi, lo);
`else
  modport master(output mult_start, div_start, a, b, input busy, done, div_zero, hi, lo);
  modport slave(input mult_start, div_start, a, b, output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed mul/div owning HI/LO; `define MULTDIV_UNSIGNED_EN adds unsigned_op (multu/divu)
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] work_hi, nxt_hi, mul_sum, trial, diff;
  logic [WIDTH-1:0] work_lo, nxt_lo, dvs, mag_a, mag_b, quo_fix, rem_fix, hi, lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic neg_q, neg_r, sa, sb, uns, busy, done, div_zero;
`ifdef MULTDIV_UNSIGNED_EN
  assign uns = bus.unsigned_op;
`else
  assign uns = 1'b0;
`endif
  // Both ops iterate on magnitudes; signs are restored when results are written.
  always_comb begin
    sa = !uns & bus.a[WIDTH-1];
    sb = !uns & bus.b[WIDTH-1];
    mag_a = sa ? -bus.a : bus.a;
    mag_b = sb ? -bus.b : bus.b;
    mul_sum = work_hi + (work_lo[0] ? {1'b0, dvs} : '0);
    trial = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
    diff = trial - {1'b0, dvs};
    nxt_hi = state == DIV ? (diff[WIDTH] ? trial : diff) : mul_sum >> 1;
    nxt_lo = state == DIV ? {work_lo[WIDTH-2:0], !diff[WIDTH]} : {mul_sum[0], work_lo[WIDTH-1:1]};
    prod = {nxt_hi[WIDTH-1:0], nxt_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix = neg_q ? -nxt_lo : nxt_lo;
    rem_fix = neg_r ? -nxt_hi[WIDTH-1:0] : nxt_hi[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      work_hi <= '0;
      work_lo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.mult_start || bus.div_start) begin
          work_hi <= '0;
          work_lo <= mag_a;
          dvs <= mag_b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt <= CW'(WIDTH);
          if (!bus.mult_start && bus.b == '0) begin
            state <= DONE;
            done <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            state <= bus.mult_start ? MULT : DIV;
            busy <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        MULT, DIV: begin
          work_hi <= nxt_hi;
          work_lo <= nxt_lo;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            {hi, lo} <= state == MULT ? prod_fix : {rem_fix, quo_fix};
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule
